// File: rtl/program_memory.sv
// program_memory: loadable instruction store with a registered fetch port and a valid/ready load port.
// Optional PROGRAM_MEMORY_BOOT_EN serves addresses 0-15 from a fixed boot program instead of RAM.
module program_memory #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  input  logic                  iFetch,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oInstructionValid,
  output logic                  oBusy,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH-1:0] iLoadBase,
  input  logic [ADDR_WIDTH-1:0] iLoadCount,
  input  logic [DATA_WIDTH-1:0] iLoadData,
  input  logic                  iLoadValid,
  output logic                  oLoadReady,
  output logic                  oLoadDone,
  output logic                  oLoadError
);

  localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rc;
  logic                  busy_r;
  logic                  ready_r;
  logic                  done_r;
  logic                  err_r;
  logic [DATA_WIDTH-1:0] instr_r;
  logic                  ivld_r;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  wp_oob;
  logic                  rd_oob;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

`ifdef PROGRAM_MEMORY_BOOT_EN
  localparam logic [ADDR_WIDTH-1:0] BOOT_WORDS = ADDR_WIDTH'(16);

  // LED countdown: r1 counts 15..1 onto the LEDs, r2 is the inner delay loop.
  // Encoding is {opcode[3:0], f0[7:0], f1[7:0], f2[7:0]}.
  function automatic logic [DATA_WIDTH-1:0] boot_word(input logic [3:0] a);
    boot_word = DEFAULT_WORD;
    case (a)
      4'd0:    boot_word = DATA_WIDTH'(28'h1_01_0F_00);
      4'd1:    boot_word = DATA_WIDTH'(28'h2_01_00_00);
      4'd2:    boot_word = DATA_WIDTH'(28'h1_02_FF_00);
      4'd3:    boot_word = DATA_WIDTH'(28'h3_02_02_01);
      4'd4:    boot_word = DATA_WIDTH'(28'h4_02_03_00);
      4'd5:    boot_word = DATA_WIDTH'(28'h3_01_01_01);
      4'd6:    boot_word = DATA_WIDTH'(28'h4_01_01_00);
      4'd7:    boot_word = DATA_WIDTH'(28'h5_00_00_00);
      default: boot_word = DEFAULT_WORD;
    endcase
  endfunction
`endif

  assign accept = iLoadValid && ready_r;
  assign wp_oob = {1'b0, wp} >= DEPTH_X;
  assign rd_oob = {1'b0, iAddress} >= DEPTH_X;
  assign wr_idx = wp[IDX_W-1:0];
  assign rd_idx = iAddress[IDX_W-1:0];

  always_comb begin
    wr_en = accept && !wp_oob;
`ifdef PROGRAM_MEMORY_BOOT_EN
    if (wp < BOOT_WORDS) wr_en = 1'b0;
`endif
  end

  always_comb begin
    rd_word = DEFAULT_WORD;
    if (!rd_oob) rd_word = mem[rd_idx];
`ifdef PROGRAM_MEMORY_BOOT_EN
    if (iAddress < BOOT_WORDS) rd_word = boot_word(iAddress[3:0]);
`endif
  end

  // Storage array: never reset, so a reset mid-load keeps words already written.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_idx] <= iLoadData;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      wp      <= '0;
      rc      <= '0;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      instr_r <= DEFAULT_WORD;
      ivld_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;

      // Fetch is stalled while a load owns the array.
      if (iFetch) begin
        if (state == LOAD) begin
          instr_r <= DEFAULT_WORD;
          ivld_r  <= 1'b0;
        end else begin
          instr_r <= rd_word;
          ivld_r  <= 1'b1;
        end
      end else begin
        ivld_r <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (iLoadStart) begin
            wp    <= iLoadBase;
            rc    <= iLoadCount;
            err_r <= 1'b0;
            if (iLoadCount == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state   <= LOAD;
              busy_r  <= 1'b1;
              ready_r <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (wp_oob) begin
              // Overflow aborts the load without a done pulse.
              err_r   <= 1'b1;
              state   <= IDLE;
              busy_r  <= 1'b0;
              ready_r <= 1'b0;
            end else begin
              wp <= wp + ONE;
              rc <= rc - ONE;
              if (rc == ONE) begin
                state   <= DONE;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
                ready_r <= 1'b0;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign oInstruction      = instr_r;
  assign oInstructionValid = ivld_r;
  assign oBusy             = busy_r;
  assign oLoadReady        = ready_r;
  assign oLoadDone         = done_r;
  assign oLoadError        = err_r;

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: scenario tasks plus randomized loads against an array model.
module tb_program_memory;

  localparam int          DEPTH = 256;
  localparam logic [27:0] DEFW  = 28'h0000000;

  logic        Clock;
  logic        Reset;
  logic [15:0] iAddress;
  logic        iFetch;
  logic [27:0] oInstruction;
  logic        oInstructionValid;
  logic        oBusy;
  logic        iLoadStart;
  logic [15:0] iLoadBase;
  logic [15:0] iLoadCount;
  logic [27:0] iLoadData;
  logic        iLoadValid;
  logic        oLoadReady;
  logic        oLoadDone;
  logic        oLoadError;

  int vectors;
  int miscompares;

  logic [27:0] ref_mem [DEPTH];
  bit          known   [DEPTH];
  logic [27:0] ld_data [16];

  program_memory #(
    .DATA_WIDTH(28), .ADDR_WIDTH(16), .DEPTH(DEPTH), .DEFAULT_WORD(DEFW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iAddress(iAddress), .iFetch(iFetch),
    .oInstruction(oInstruction), .oInstructionValid(oInstructionValid), .oBusy(oBusy),
    .iLoadStart(iLoadStart), .iLoadBase(iLoadBase), .iLoadCount(iLoadCount),
    .iLoadData(iLoadData), .iLoadValid(iLoadValid), .oLoadReady(oLoadReady),
    .oLoadDone(oLoadDone), .oLoadError(oLoadError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Writes the words a load of cnt beats from base would store; err=1 if it overflows.
  task automatic model_apply(input int base, input int cnt, output bit err);
    err = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (base + i >= DEPTH) begin
        err = 1'b1;
        break;
      end
      ref_mem[base + i] = ld_data[i % 16];
      known[base + i]   = 1'b1;
    end
  endtask

  task automatic fetch(input logic [15:0] a, output logic [27:0] d, output logic v);
    iAddress = a;
    iFetch   = 1'b1;
    tick();
    d      = oInstruction;
    v      = oInstructionValid;
    iFetch = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: alternating 1/0, 2: random.
  task automatic run_load(input logic [15:0] base, input logic [15:0] cnt, input int mode,
                          output int edges, output int beats, output bit done,
                          output bit err, output bit tmo);
    bit v;
    bit tg;
    bit acc;
    iLoadBase  = base;
    iLoadCount = cnt;
    iLoadStart = 1'b1;
    iLoadValid = 1'b0;
    tick();
    iLoadStart = 1'b0;
    edges = 0; beats = 0; done = 1'b0; err = 1'b0; tmo = 1'b1; tg = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (oLoadDone)  begin done = 1'b1; tmo = 1'b0; break; end
      if (oLoadError) begin err  = 1'b1; tmo = 1'b0; break; end
      if (!oBusy)     begin tmo  = 1'b0; break; end
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tg; tg = !tg; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (beats >= int'(cnt)) v = 1'b0;
      iLoadValid = v;
      iLoadData  = v ? ld_data[beats % 16] : 28'hBADBAD0 ^ 28'(k);
      acc = v && oLoadReady;
      tick();
      edges++;
      if (acc) beats++;
    end
    iLoadValid = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] d;
    logic        v;
    Reset = 1'b1; iLoadStart = 1'b1; iLoadBase = 16'h0010; iLoadCount = 16'h0003; iFetch = 1'b1;
    tick();
    tick();
    vectors++;
    if ({oBusy, oLoadReady, oLoadDone, oLoadError, oInstructionValid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_status got busy/ready/done/err/vld=%b exp 00000",
               {oBusy, oLoadReady, oLoadDone, oLoadError, oInstructionValid});
    end
    vectors++;
    if (oInstruction !== DEFW) begin
      miscompares++;
      $display("FAIL reset_instr got %h exp %h", oInstruction, DEFW);
    end
    Reset = 1'b0; iLoadStart = 1'b0; iFetch = 1'b0;
    tick();
    vectors++;
    if (oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_ignored got busy=%b exp 0", oBusy);
    end
    fetch(16'h1234, d, v);
    vectors++;
    if (d !== DEFW || v !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_fetch_oob got %h/%b exp %h/1", d, v, DEFW);
    end
  endtask

  task automatic test_load_basic();
    int edges, beats; bit done, err, tmo, merr;
    logic [27:0] d; logic v;
    for (int i = 0; i < 4; i++) ld_data[i] = 28'(32'hA0 + i);
    run_load(16'h0020, 16'd4, 0, edges, beats, done, err, tmo);
    model_apply(32'h20, 4, merr);
    vectors++;
    if (done !== 1'b1 || err !== merr || tmo !== 1'b0 || edges != 4 || beats != 4) begin
      miscompares++;
      $display("FAIL basic_load got done=%b err=%b tmo=%b edges=%0d beats=%0d exp 1 0 0 4 4",
               done, err, tmo, edges, beats);
    end
    tick();
    vectors++;
    if (oLoadDone !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_width got %b exp 0", oLoadDone);
    end
    for (int i = 0; i < 4; i++) begin
      fetch(16'(32'h20 + i), d, v);
      vectors++;
      if (d !== ref_mem[32'h20 + i] || v !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_readback[%0d] got %h/%b exp %h/1", i, d, v, ref_mem[32'h20 + i]);
      end
    end
  endtask

  task automatic test_valid_toggle();
    int edges, beats; bit done, err, tmo, merr;
    logic [27:0] d; logic v;
    for (int i = 0; i < 4; i++) ld_data[i] = 28'(32'hB0 + i);
    run_load(16'h0040, 16'd4, 1, edges, beats, done, err, tmo);
    model_apply(32'h40, 4, merr);
    vectors++;
    if (done !== 1'b1 || err !== merr || tmo !== 1'b0 || edges != 7 || beats != 4) begin
      miscompares++;
      $display("FAIL toggle_load got done=%b err=%b tmo=%b edges=%0d beats=%0d exp 1 0 0 7 4",
               done, err, tmo, edges, beats);
    end
    for (int i = 0; i < 4; i++) begin
      fetch(16'(32'h40 + i), d, v);
      vectors++;
      if (d !== ref_mem[32'h40 + i] || v !== 1'b1) begin
        miscompares++;
        $display("FAIL toggle_readback[%0d] got %h/%b exp %h/1", i, d, v, ref_mem[32'h40 + i]);
      end
    end
  endtask

  task automatic test_overflow();
    int edges, beats; bit done, err, tmo, merr;
    logic [27:0] d; logic v;
    for (int i = 0; i < 4; i++) ld_data[i] = 28'(32'hE0 + i);
    run_load(16'(DEPTH - 2), 16'd4, 0, edges, beats, done, err, tmo);
    model_apply(DEPTH - 2, 4, merr);
    vectors++;
    if (err !== merr || done !== 1'b0 || tmo !== 1'b0 || beats != 3) begin
      miscompares++;
      $display("FAIL overflow_load got err=%b done=%b tmo=%b beats=%0d exp 1 0 0 3",
               err, done, tmo, beats);
    end
    tick();
    vectors++;
    if ({oLoadError, oLoadDone, oBusy} !== 3'b100) begin
      miscompares++;
      $display("FAIL overflow_sticky got err/done/busy=%b exp 100", {oLoadError, oLoadDone, oBusy});
    end
    for (int i = 0; i < 2; i++) begin
      fetch(16'(DEPTH - 2 + i), d, v);
      vectors++;
      if (d !== ref_mem[DEPTH - 2 + i] || v !== 1'b1) begin
        miscompares++;
        $display("FAIL overflow_readback[%0d] got %h/%b exp %h/1", i, d, v, ref_mem[DEPTH - 2 + i]);
      end
    end
    iLoadBase = 16'h0060; iLoadCount = 16'd1; iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    vectors++;
    if (oLoadError !== 1'b0 || oBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_clear got err=%b busy=%b exp 0 1", oLoadError, oBusy);
    end
    ld_data[0] = 28'h0000E60;
    iLoadValid = 1'b1; iLoadData = ld_data[0];
    tick();
    iLoadValid = 1'b0;
    model_apply(32'h60, 1, merr);
    vectors++;
    if (oLoadDone !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_reload_done got %b exp 1", oLoadDone);
    end
    tick();
  endtask

  task automatic test_count_zero();
    int edges, beats; bit done, err, tmo;
    logic [27:0] d; logic v;
    ld_data[0] = 28'hFFFFFFF;
    run_load(16'h0020, 16'd0, 0, edges, beats, done, err, tmo);
    vectors++;
    if (done !== 1'b1 || edges != 0 || err !== 1'b0 || tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done got done=%b edges=%0d err=%b tmo=%b exp 1 0 0 0", done, edges, err, tmo);
    end
    tick();
    vectors++;
    if (oLoadDone !== 1'b0 || oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_after got done=%b busy=%b exp 0 0", oLoadDone, oBusy);
    end
    for (int i = 0; i < 4; i++) begin
      fetch(16'(32'h20 + i), d, v);
      vectors++;
      if (d !== ref_mem[32'h20 + i]) begin
        miscompares++;
        $display("FAIL zero_unchanged[%0d] got %h exp %h", i, d, ref_mem[32'h20 + i]);
      end
    end
  endtask

  task automatic test_fetch_during_load();
    logic [27:0] d; logic v;
    iLoadBase = 16'h0080; iLoadCount = 16'd2; iLoadStart = 1'b1;
    tick();
    iLoadBase = 16'h0090; iLoadCount = 16'd5;
    iFetch = 1'b1; iAddress = 16'h0020; iLoadValid = 1'b0;
    tick();
    iLoadStart = 1'b0;
    vectors++;
    if (oInstruction !== DEFW || oInstructionValid !== 1'b0 || oBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL load_fetch_stall got %h/%b busy=%b exp %h/0 busy=1",
               oInstruction, oInstructionValid, oBusy, DEFW);
    end
    iLoadValid = 1'b1; iLoadData = 28'h00000C0;
    tick();
    iLoadData = 28'h00000C1; iAddress = 16'h0081;
    tick();
    vectors++;
    if (oLoadDone !== 1'b1 || oInstruction !== DEFW || oInstructionValid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_final_fetch got done=%b %h/%b exp 1 %h/0",
               oLoadDone, oInstruction, oInstructionValid, DEFW);
    end
    iLoadValid = 1'b0;
    ref_mem[32'h80] = 28'h00000C0; known[32'h80] = 1'b1;
    ref_mem[32'h81] = 28'h00000C1; known[32'h81] = 1'b1;
    tick();
    vectors++;
    if (oInstruction !== ref_mem[32'h81] || oInstructionValid !== 1'b1 || oLoadDone !== 1'b0) begin
      miscompares++;
      $display("FAIL done_cycle_fetch got %h/%b done=%b exp %h/1 done=0",
               oInstruction, oInstructionValid, oLoadDone, ref_mem[32'h81]);
    end
    iFetch = 1'b0;
    tick();
    vectors++;
    if (oInstruction !== ref_mem[32'h81] || oInstructionValid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_hold got %h/%b exp %h/0", oInstruction, oInstructionValid, ref_mem[32'h81]);
    end
    fetch(16'h0080, d, v);
    vectors++;
    if (d !== ref_mem[32'h80] || v !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ignored_readback got %h/%b exp %h/1", d, v, ref_mem[32'h80]);
    end
  endtask

  task automatic test_reset_midload();
    logic [27:0] d; logic v;
    iLoadBase = 16'h00A0; iLoadCount = 16'd4; iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    iLoadValid = 1'b1; iLoadData = 28'h00000D0;
    tick();
    iLoadData = 28'h00000D1;
    tick();
    iLoadValid = 1'b0;
    ref_mem[32'hA0] = 28'h00000D0; known[32'hA0] = 1'b1;
    ref_mem[32'hA1] = 28'h00000D1; known[32'hA1] = 1'b1;
    Reset = 1'b1;
    tick();
    vectors++;
    if ({oBusy, oLoadReady, oLoadDone, oLoadError, oInstructionValid} !== 5'b0 ||
        oInstruction !== DEFW) begin
      miscompares++;
      $display("FAIL midload_reset got status=%b instr=%h exp 00000 %h",
               {oBusy, oLoadReady, oLoadDone, oLoadError, oInstructionValid}, oInstruction, DEFW);
    end
    Reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      fetch(16'(32'hA0 + i), d, v);
      vectors++;
      if (d !== ref_mem[32'hA0 + i] || v !== 1'b1) begin
        miscompares++;
        $display("FAIL midload_retained[%0d] got %h/%b exp %h/1", i, d, v, ref_mem[32'hA0 + i]);
      end
    end
  endtask

  task automatic test_random();
    int edges, beats, base, cnt, exp_beats; bit done, err, tmo, merr;
    logic [27:0] d; logic v;
    for (int t = 0; t < 12; t++) begin
      base = $urandom_range(16, DEPTH - 1);
      cnt  = $urandom_range(1, 8);
      for (int i = 0; i < 16; i++) ld_data[i] = 28'($urandom);
      run_load(16'(base), 16'(cnt), 2, edges, beats, done, err, tmo);
      model_apply(base, cnt, merr);
      exp_beats = merr ? (DEPTH - base + 1) : cnt;
      vectors++;
      if (err !== merr || done !== !merr || tmo !== 1'b0 || beats != exp_beats) begin
        miscompares++;
        $display("FAIL rand_load[%0d] base=%0d cnt=%0d got err=%b done=%b tmo=%b beats=%0d exp err=%b beats=%0d",
                 t, base, cnt, err, done, tmo, beats, merr, exp_beats);
      end
      tick();
      for (int a = base; a < base + cnt && a < DEPTH; a++) begin
        fetch(16'(a), d, v);
        vectors++;
        if (d !== ref_mem[a] || v !== 1'b1) begin
          miscompares++;
          $display("FAIL rand_readback addr=%0d got %h/%b exp %h/1", a, d, v, ref_mem[a]);
        end
      end
      fetch(16'($urandom_range(DEPTH, 16'hFFFF)), d, v);
      vectors++;
      if (d !== DEFW || v !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_oob[%0d] got %h/%b exp %h/1", t, d, v, DEFW);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    Reset = 1'b0; iAddress = '0; iFetch = 1'b0; iLoadStart = 1'b0;
    iLoadBase = '0; iLoadCount = '0; iLoadData = '0; iLoadValid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      known[i]   = 1'b0;
      ref_mem[i] = DEFW;
    end
    for (int i = 0; i < 16; i++) ld_data[i] = '0;
    test_reset();
    test_load_basic();
    test_valid_toggle();
    test_overflow();
    test_count_zero();
    test_fetch_during_load();
    test_reset_midload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
